// File: rtl/keypad_emulator.sv
// Emulates a 4x4 matrix keypad: pulls a row line low when the pressed key's
// column is strobed, running a timed bounce/hold/gap contact sequence per press.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 2000000,
  parameter int BOUNCE_CYCLES = 200000,
  parameter int BOUNCE_PERIOD = 10000,
  parameter int GAP_CYCLES    = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] active_key,
  output logic       contact,
  output logic       done,
  output logic [1:0] dbg_state_o
);

  localparam int MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_PG  = (BOUNCE_PERIOD > GAP_CYCLES) ? BOUNCE_PERIOD : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HB > MAX_PG) ? MAX_HB : MAX_PG;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(BOUNCE_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE         = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, BOUNCE = 2'd1, HOLD = 2'd2, GAP = 2'd3} state_e;

  // Handshake: a request transfers on any rising clk edge where key_valid and
  // key_ready are both high; key_ready is high exactly while the FSM is IDLE.
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] ph_q;
  logic          contact_q;
  logic          done_q;
  logic [3:0]    key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      key_q     <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            key_q     <= key_code;
            contact_q <= 1'b1;
            cnt_q     <= '0;
            ph_q      <= '0;
            state_q   <= (BOUNCE_CYCLES > 0) ? BOUNCE : HOLD;
          end
        end
        BOUNCE: begin
          if (cnt_q == BOUNCE_LAST) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            contact_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
            // ph_q tracks position inside the current open/closed half-period
            if (ph_q == PERIOD_LAST) begin
              ph_q      <= '0;
              contact_q <= ~contact_q;
            end else begin
              ph_q <= ph_q + ONE;
            end
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q     <= '0;
            contact_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [1:0] row_idx;
  logic [1:0] col_idx;

  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    case (key_q)
      4'h1: begin row_idx = 2'd0; col_idx = 2'd0; end
      4'h2: begin row_idx = 2'd0; col_idx = 2'd1; end
      4'h3: begin row_idx = 2'd0; col_idx = 2'd2; end
      4'hA: begin row_idx = 2'd0; col_idx = 2'd3; end
      4'h4: begin row_idx = 2'd1; col_idx = 2'd0; end
      4'h5: begin row_idx = 2'd1; col_idx = 2'd1; end
      4'h6: begin row_idx = 2'd1; col_idx = 2'd2; end
      4'hB: begin row_idx = 2'd1; col_idx = 2'd3; end
      4'h7: begin row_idx = 2'd2; col_idx = 2'd0; end
      4'h8: begin row_idx = 2'd2; col_idx = 2'd1; end
      4'h9: begin row_idx = 2'd2; col_idx = 2'd2; end
      4'hC: begin row_idx = 2'd2; col_idx = 2'd3; end
      4'h0: begin row_idx = 2'd3; col_idx = 2'd0; end
      4'hF: begin row_idx = 2'd3; col_idx = 2'd1; end
      4'hE: begin row_idx = 2'd3; col_idx = 2'd2; end
      4'hD: begin row_idx = 2'd3; col_idx = 2'd3; end
      default: begin row_idx = 2'd0; col_idx = 2'd0; end
    endcase
  end

  always_comb begin
    rows = 4'b1111;
    if (contact_q && !cols[col_idx]) rows[row_idx] = 1'b0;
  end

  assign key_ready   = (state_q == IDLE);
  assign active_key  = key_q;
  assign contact     = contact_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: three parameterisations checked every cycle
// against a sequence-position model, plus directed literal checks.
module tb_keypad_emulator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] cols_v[3]     = '{4'hF, 4'hF, 4'hF};
  logic [3:0] key_code_v[3] = '{4'h0, 4'h0, 4'h0};
  logic       key_valid_v[3] = '{1'b0, 1'b0, 1'b0};
  logic [3:0] rows_v[3];
  logic [3:0] active_v[3];
  logic       ready_v[3];
  logic       contact_v[3];
  logic       done_v[3];
  logic [1:0] dbg_v[3];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  keypad_emulator #(.HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .cols(cols_v[0]), .rows(rows_v[0]), .key_code(key_code_v[0]),
    .key_valid(key_valid_v[0]), .key_ready(ready_v[0]), .active_key(active_v[0]),
    .contact(contact_v[0]), .done(done_v[0]), .dbg_state_o(dbg_v[0]));

  keypad_emulator #(.HOLD_CYCLES(5), .BOUNCE_CYCLES(10), .BOUNCE_PERIOD(3), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .cols(cols_v[1]), .rows(rows_v[1]), .key_code(key_code_v[1]),
    .key_valid(key_valid_v[1]), .key_ready(ready_v[1]), .active_key(active_v[1]),
    .contact(contact_v[1]), .done(done_v[1]), .dbg_state_o(dbg_v[1]));

  keypad_emulator #(.HOLD_CYCLES(1), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .cols(cols_v[2]), .rows(rows_v[2]), .key_code(key_code_v[2]),
    .key_valid(key_valid_v[2]), .key_ready(ready_v[2]), .active_key(active_v[2]),
    .contact(contact_v[2]), .done(done_v[2]), .dbg_state_o(dbg_v[2]));

  function automatic int p_hold(int j);   return (j == 0) ? 8 : (j == 1) ? 5 : 1;  endfunction
  function automatic int p_bounce(int j); return (j == 1) ? 10 : 0;                endfunction
  function automatic int p_period(int j); return (j == 1) ? 3 : 1;                 endfunction
  function automatic int p_gap(int j);    return (j == 0) ? 4 : (j == 1) ? 2 : 0;  endfunction

  // ---------------- behavioural model ----------------
  // m_pos = cycles since the press was accepted (-1 when idle).
  int         m_pos[3]  = '{-1, -1, -1};
  logic [3:0] m_key[3]  = '{4'h0, 4'h0, 4'h0};
  bit         m_done[3] = '{1'b0, 1'b0, 1'b0};
  int         m_hs[3]   = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        m_pos[j]  = -1;
        m_key[j]  = 4'h0;
        m_done[j] = 1'b0;
      end else if (m_pos[j] < 0) begin
        m_done[j] = 1'b0;
        if (key_valid_v[j]) begin
          m_pos[j] = 0;
          m_key[j] = key_code_v[j];
          m_hs[j]++;
        end
      end else begin
        m_pos[j]++;
        if (m_pos[j] == p_bounce(j) + p_hold(j) + p_gap(j)) begin
          m_pos[j]  = -1;
          m_done[j] = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_contact(int j, int p);
    if (p < 0) return 1'b0;
    if (p < p_bounce(j)) return ((p / p_period(j)) % 2) == 0;
    if (p < p_bounce(j) + p_hold(j)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_rows(logic [3:0] key, logic [3:0] c, logic con);
    logic [3:0] lay [4][4];
    logic [3:0] r;
    lay = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
            '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'h0, 4'hF, 4'hE, 4'hD}};
    r = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (lay[ri][ci] == key && con && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic check(input string name, input int j, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, j, $time, got, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        check("contact", j, {3'b0, contact_v[j]}, {3'b0, exp_contact(j, m_pos[j])});
        check("rows", j, rows_v[j], exp_rows(m_key[j], cols_v[j], exp_contact(j, m_pos[j])));
        check("key_ready", j, {3'b0, ready_v[j]}, {3'b0, m_pos[j] < 0});
        check("done", j, {3'b0, done_v[j]}, {3'b0, m_done[j]});
        check("active_key", j, active_v[j], m_key[j]);
        check("idle_state", j, {3'b0, dbg_v[j] == 2'd0}, {3'b0, m_pos[j] < 0});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int j);
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready_v[j]) begin ok = 1'b1; break; end
    end
    if (!ok) check("ready_timeout", j, 4'h0, 4'h1);
  endtask

  // Returns #1 after the handshake edge, i.e. at the start of sequence cycle 0.
  task automatic press(input int j, input logic [3:0] code);
    wait_ready(j);
    @(posedge clk);
    #1;
    key_code_v[j]  = code;
    key_valid_v[j] = 1'b1;
    @(posedge clk);
    #1;
    key_valid_v[j] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] sw [4];
    logic [3:0] keys_l [4];
    logic [3:0] colp_l [4];
    logic [3:0] rowp_l [4];
    logic       lit1 [16];
    logic [3:0] code;
    bit         hs;
    int         hs0;

    sw     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    keys_l = '{4'h5, 4'h0, 4'hD, 4'hA};
    colp_l = '{4'b1101, 4'b1110, 4'b0111, 4'b0111};
    rowp_l = '{4'b1101, 4'b0111, 4'b0111, 4'b1110};
    lit1   = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_rows", 0, rows_v[0], 4'b1111);
    check("rst_contact", 0, {3'b0, contact_v[0]}, 4'h0);
    check("rst_ready", 0, {3'b0, ready_v[0]}, 4'h1);
    check("rst_done", 0, {3'b0, done_v[0]}, 4'h0);
    check("rst_active", 0, active_v[0], 4'h0);

    // Basic press: key 5, cols 1101, hold 8 / gap 4
    cols_v[0] = 4'b1101;
    press(0, 4'h5);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("lit_contact", 0, {3'b0, contact_v[0]}, {3'b0, i < 8});
      check("lit_rows", 0, rows_v[0], (i < 8) ? 4'b1101 : 4'b1111);
      check("lit_done", 0, {3'b0, done_v[0]}, {3'b0, i == 12});
      check("lit_ready", 0, {3'b0, ready_v[0]}, {3'b0, i >= 12});
    end

    // Column sweep during HOLD for corner keys
    for (int k = 0; k < 4; k++) begin
      cols_v[0] = 4'b1111;
      press(0, keys_l[k]);
      for (int i = 0; i < 8; i++) begin
        cols_v[0] = sw[i % 4];
        @(negedge clk);
        check("sweep_rows", 0, rows_v[0], (sw[i % 4] == colp_l[k]) ? rowp_l[k] : 4'b1111);
        @(posedge clk);
        #1;
      end
    end
    cols_v[0] = 4'b1111;

    // Bounce pattern
    cols_v[1] = 4'b0000;
    press(1, 4'h9);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bounce_contact", 1, {3'b0, contact_v[1]}, {3'b0, lit1[i]});
    end

    // HOLD=1, GAP=0: straight back to IDLE
    press(2, 4'h3);
    @(negedge clk);
    check("h1_contact", 2, {3'b0, contact_v[2]}, 4'h1);
    check("h1_done", 2, {3'b0, done_v[2]}, 4'h0);
    @(negedge clk);
    check("h1_contact_off", 2, {3'b0, contact_v[2]}, 4'h0);
    check("h1_done_pulse", 2, {3'b0, done_v[2]}, 4'h1);
    @(negedge clk);
    check("h1_done_end", 2, {3'b0, done_v[2]}, 4'h0);

    // key_valid held high with alternating codes 1, F
    wait_ready(0);
    @(posedge clk);
    #1;
    hs0 = m_hs[0];
    code = 4'h1;
    key_code_v[0]  = code;
    key_valid_v[0] = 1'b1;
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      hs = ready_v[0];
      @(posedge clk);
      #1;
      if (hs) begin
        code = (code == 4'h1) ? 4'hF : 4'h1;
        key_code_v[0] = code;
      end
    end
    key_valid_v[0] = 1'b0;
    check("cont_presses", 0, 4'(m_hs[0] - hs0), 4'd5);
    check("cont_last_key", 0, active_v[0], 4'h1);

    // Async reset in the middle of HOLD
    press(0, 4'h7);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      check("arst_rows", j, rows_v[j], 4'b1111);
      check("arst_contact", j, {3'b0, contact_v[j]}, 4'h0);
      check("arst_ready", j, {3'b0, ready_v[j]}, 4'h1);
      check("arst_done", j, {3'b0, done_v[j]}, 4'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("arst_no_done", 0, {3'b0, done_v[0]}, 4'h0);
    end

    // Randomised traffic on all three instances
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        key_valid_v[j] = ($urandom_range(0, 3) == 0);
        key_code_v[j]  = 4'($urandom_range(0, 15));
        cols_v[j]      = 4'($urandom_range(0, 15));
      end
    end
    for (int j = 0; j < 3; j++) key_valid_v[j] = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
